apb_slave_regs: RTL
===================

# apb_slave_regs

APB completer answering transfers from the team's APB master at base address 0xA000. Holds a small bank of 32-bit registers: index 0 is a read-only ID word, the rest are read/write. Inserts a configurable number of wait states and flags invalid accesses with P_slverr. It is the design-side responder the incrementor master reads from and writes back to.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_A000, byte address of register 0.
- NUM_REGS, 8, number of 32-bit registers; legal range 2..16.
- WAIT_STATES, 2, wait cycles per transfer when APB_SLV_WAIT_EN is defined; legal range 0..7.
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- Pclk  in  1  clock; all state changes on the rising edge.
- Prst  in  1  reset, asynchronous, active-low.
- Paddr  in  32  byte address from the master.
- PSELx  in  1  slave select.
- P_en  in  1  enable; high in access phase.
- P_WR  in  1  1 = write, 0 = read.
- PWdata  in  32  write data.
- PRdata  out  32  read data; valid only while P_ready=1 on a read, otherwise 0.
- P_ready  out  1  transfer-complete flag.
- P_slverr  out  1  error flag; valid only while P_ready=1, otherwise 0.

## Operation
- Reset: state IDLE, wait counter 0, registers 1..NUM_REGS-1 = 0. Outputs PRdata=0, P_ready=0, P_slverr=0.
- Decode: offset = Paddr - BASE_ADDR (32-bit unsigned subtract; wrap below BASE_ADDR yields a large offset). Index = offset[31:2].
- An access is invalid if offset[1:0] != 0, index >= NUM_REGS, or a write targets index 0.
- States:
  - IDLE: on an edge with PSELx=1, P_en=0 (setup phase), go to ACCESS and load the counter with the wait count. Otherwise stay.
  - ACCESS: P_ready = PSELx & P_en & (counter == 0). Each edge with counter != 0 decrements it. On an edge with P_ready=1, return to IDLE.
  - ACCESS, PSELx low before completion: abort to IDLE. No write commits and no response is produced.
- Write commit: on the completing edge only, and only for a valid access. Invalid writes leave all registers unchanged.
- Read: while P_ready=1, PRdata = register[index] if valid, else 0.
- P_slverr: equals invalid, asserted only while P_ready=1.
- Address, P_WR and PWdata are sampled combinationally each cycle. The master is required to hold them stable through the access phase.
- A 2-bit state encoding is used. An unused encoding returns to IDLE on the next edge.

## Timing
- Setup at edge k-1. First access cycle k. P_ready is high in cycle k+W, where W is the wait count, and the transfer completes at the end of that cycle.
- Back-to-back transfers are supported. A setup phase immediately after completion is seen in IDLE, giving W+2 cycles per transfer minimum.
- Reset asserted mid-transfer immediately forces IDLE and drops P_ready, P_slverr and PRdata to 0. The transfer is lost and no write commits.
- P_en=1 while in IDLE (no preceding setup) is a protocol error. It is ignored and P_ready stays 0.

## Configuration
- APB_SLV_WAIT_EN defined: the wait count is WAIT_STATES, so P_ready rises WAIT_STATES cycles into the access phase.
- APB_SLV_WAIT_EN not defined: the wait count is forced to 0, so P_ready is high in the first access cycle (zero-wait slave) and WAIT_STATES is ignored.

## Test plan
- Reset, then read 0xA000 (wait enabled, W=2) -> P_ready low 2 access cycles then high; PRdata=0xA5B0_0001, P_slverr=0.
- Write 0x0000_1234 to 0xA004, then read 0xA004 -> PRdata=0x0000_1234, P_slverr=0 on both transfers.
- Write 0xDEAD_BEEF to 0xA000, and separately to 0xA020 (index 8) -> P_slverr=1 on both; a following read of 0xA000 still returns 0xA5B0_0001.
- Read misaligned 0xA006 and below-base 0x9FFC -> P_slverr=1, PRdata=0.
- Write 0x55 to 0xA008, dropping PSELx after 1 access cycle (W=2) -> no P_ready; a read of 0xA008 returns 0. Repeat with Prst pulsed mid-access -> same result, all outputs 0 during reset.
- Without APB_SLV_WAIT_EN: back-to-back write 0x77 to 0xA00C then read 0xA00C -> P_ready high in each first access cycle; read returns 0x77.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB completer with a small 32-bit register bank at BASE_ADDR; register 0 is a read-only ID.
// Wait states are inserted only when APB_SLV_WAIT_EN is defined; otherwise it is a zero-wait slave.
module apb_slave_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        Pclk,
  input  logic        Prst,
  input  logic [31:0] Paddr,
  input  logic        PSELx,
  input  logic        P_en,
  input  logic        P_WR,
  input  logic [31:0] PWdata,
  output logic [31:0] PRdata,
  output logic        P_ready,
  output logic        P_slverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01
  } state_e;

  if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("apb_slave_regs: NUM_REGS must be in 2..16");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
    $error("apb_slave_regs: WAIT_STATES must be in 0..7");
  end

`ifdef APB_SLV_WAIT_EN
  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);
`else
  localparam logic [2:0] WAIT_CNT = 3'd0;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [1:NUM_REGS-1];

  logic [31:0] offset;
  logic [3:0]  idx;
  logic        in_range;
  logic        invalid;
  logic        ready;
  logic        commit;
  logic [31:0] rd_word;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range naturally.
  assign offset   = Paddr - BASE_ADDR;
  assign idx      = offset[5:2];
  assign in_range = offset[31:2] < 30'(NUM_REGS);
  assign invalid  = (offset[1:0] != 2'b00) | ~in_range | (P_WR & (idx == 4'd0));

  assign ready  = (state_q == ST_ACCESS) & PSELx & P_en & (cnt_q == 3'd0);
  assign commit = ready & P_WR & ~invalid;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (PSELx && !P_en) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_CNT;
        end
      end
      ST_ACCESS: begin
        if (!PSELx) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the bank is small flop storage with defined reset contents, so it is reset like any register.
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == 4'(i)) begin
          regs_q[i] <= PWdata;
        end
      end
    end
  end

  // Mux by comparison rather than direct indexing so out-of-range indices never address the array.
  always_comb begin
    rd_word = (idx == 4'd0) ? ID_VALUE : 32'd0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  assign P_ready  = ready;
  assign P_slverr = ready & invalid;
  assign PRdata   = (ready && !P_WR && !invalid) ? rd_word : 32'd0;

endmodule
